// File: rtl/watch_pkg.sv
// Shared types and constants for the watch time-setting sequencer.
//   set_state_t : RUN / SET_HOUR / SET_MIN / SET_SEC
//   FIELD_*     : sel_field encodings (hour, minute, second, none)
//   field_of    : sel_field value shown for a given state
//   next_field  : SELECT rotation hour -> minute -> second -> hour
package watch_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    SET_SEC  = 2'd3
  } set_state_t;

  localparam logic [1:0] FIELD_HOUR = 2'd0;
  localparam logic [1:0] FIELD_MIN  = 2'd1;
  localparam logic [1:0] FIELD_SEC  = 2'd2;
  localparam logic [1:0] FIELD_NONE = 2'd3;

  function automatic logic [1:0] field_of(input set_state_t s);
    case (s)
      SET_HOUR: return FIELD_HOUR;
      SET_MIN:  return FIELD_MIN;
      SET_SEC:  return FIELD_SEC;
      default:  return FIELD_NONE;
    endcase
  endfunction

  function automatic set_state_t next_field(input set_state_t s);
    case (s)
      SET_HOUR: return SET_MIN;
      SET_MIN:  return SET_SEC;
      SET_SEC:  return SET_HOUR;
      default:  return RUN;
    endcase
  endfunction

endpackage

// File: rtl/watch_set_controller_if.sv
// Button / counter-control bundle of the watch time-setting sequencer.
//   btn_*_raw      : raw active-high push-buttons, asynchronous to clk
//   mode           : 1 while in any SET_* state
//   sel_field      : 0 hour, 1 minute, 2 second, 3 none (RUN)
//   change_*       : one-cycle increment (hour/minute) or clear (second) pulses
//   valid_response : qualifier for change_*
//   blink          : display blink for the selected field
//   dbg_state      : current sequencer state, for observation only
// Handshake: there is no back-pressure. valid_response is high for exactly one
// cycle, together with exactly one change_* line; the counters must accept it
// in that cycle. change_* are meaningless while valid_response is low.
interface watch_set_controller_if;
  import watch_pkg::*;

  logic       btn_mode_raw;
  logic       btn_sel_raw;
  logic       btn_inc_raw;
  logic       mode;
  logic [1:0] sel_field;
  logic       change_hour;
  logic       change_minute;
  logic       change_second;
  logic       valid_response;
  logic       blink;
  set_state_t dbg_state;

  modport master (
    input  btn_mode_raw, btn_sel_raw, btn_inc_raw,
    output mode, sel_field, change_hour, change_minute, change_second,
           valid_response, blink, dbg_state
  );

  modport slave (
    output btn_mode_raw, btn_sel_raw, btn_inc_raw,
    input  mode, sel_field, change_hour, change_minute, change_second,
           valid_response, blink, dbg_state
  );

endinterface

// File: rtl/btn_debounce.sv
// One push-button front end: 2-FF synchronizer, debounce, rising-edge detect.
//   clk, rst : clock, asynchronous active-low reset (button reads released)
//   btn_raw  : raw active-high button
//   level    : debounced button level
//   press    : one-cycle pulse when level goes 0 -> 1
// A new level is accepted once DEBOUNCE_CYCLES consecutive synchronized
// samples disagree with the current level; any agreeing sample restarts it.
module btn_debounce #(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  logic        sync1_q;
  logic        sync2_q;
  logic [19:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level   <= 1'b0;
      press   <= 1'b0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      press   <= 1'b0;
      if (sync2_q == level) begin
        cnt_q <= '0;
      end else if (cnt_q == DEBOUNCE_CYCLES - 20'd1) begin
        cnt_q <= '0;
        level <= sync2_q;
        press <= sync2_q;
      end else begin
        cnt_q <= cnt_q + 20'd1;
      end
    end
  end

endmodule

// File: rtl/watch_set_controller.sv
// Time-setting sequencer: buttons in, counter change pulses out.
//   clk : system clock
//   rst : asynchronous active-low reset
//   bus : watch_set_controller_if.master (buttons, mode, sel_field, change_*,
//         valid_response, blink, dbg_state)
// Optional feature: define WATCH_SET_AUTOREPEAT_EN to auto-repeat a held INC in
// SET_HOUR / SET_MIN (first repeat after HOLD_CYCLES, then every REPEAT_CYCLES;
// requires HOLD_CYCLES >= REPEAT_CYCLES). Without it, one pulse per INC press.
module watch_set_controller
  import watch_pkg::*;
#(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500_000,
  parameter logic [26:0] HOLD_CYCLES     = 27'd50_000_000,
  parameter logic [26:0] REPEAT_CYCLES   = 27'd12_500_000,
  parameter logic [31:0] TIMEOUT_CYCLES  = 32'd500_000_000,
  parameter logic [26:0] BLINK_CYCLES    = 27'd25_000_000
) (
  input  logic                    clk,
  input  logic                    rst,
  watch_set_controller_if.master  bus
);

  logic mode_evt, sel_evt, inc_evt;
  logic mode_level, sel_level, inc_level;
  logic unused_levels;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
    .clk(clk), .rst(rst), .btn_raw(bus.btn_mode_raw), .level(mode_level), .press(mode_evt));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_sel (
    .clk(clk), .rst(rst), .btn_raw(bus.btn_sel_raw), .level(sel_level), .press(sel_evt));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
    .clk(clk), .rst(rst), .btn_raw(bus.btn_inc_raw), .level(inc_level), .press(inc_evt));

  assign unused_levels = ^{mode_level, sel_level, inc_level};

  set_state_t  state_q, state_d;
  logic [31:0] to_cnt_q, to_cnt_d;
  logic [26:0] blink_cnt_q, blink_cnt_d;
  logic        blink_q, blink_d;
  logic        mode_q;
  logic [1:0]  sel_q;
  logic        hour_q, min_q, sec_q, valid_q;
  logic        pulse;
  logic        rep_pulse;

`ifdef WATCH_SET_AUTOREPEAT_EN
  logic        armed_q, armed_d;
  logic [26:0] hold_cnt_q, hold_cnt_d;

  // hold_cnt counts cycles since the press that armed the repeat; after each
  // repeat it is rewound so the next one lands REPEAT_CYCLES later.
  always_comb begin
    armed_d    = armed_q;
    hold_cnt_d = hold_cnt_q;
    rep_pulse  = 1'b0;
    if ((state_q == SET_HOUR || state_q == SET_MIN) && !mode_evt && !sel_evt) begin
      if (inc_evt) begin
        armed_d    = 1'b1;
        hold_cnt_d = 27'd1;
      end else if (armed_q && inc_level) begin
        if (hold_cnt_q == HOLD_CYCLES) begin
          rep_pulse  = 1'b1;
          hold_cnt_d = HOLD_CYCLES - REPEAT_CYCLES + 27'd1;
        end else begin
          hold_cnt_d = hold_cnt_q + 27'd1;
        end
      end else begin
        armed_d = 1'b0;
      end
    end else begin
      armed_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      armed_q    <= 1'b0;
      hold_cnt_q <= '0;
    end else begin
      armed_q    <= armed_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end
`else
  localparam logic [53:0] unused_repeat_cfg = {HOLD_CYCLES, REPEAT_CYCLES};
  assign rep_pulse = 1'b0;
`endif

  // Next state, timeout and blink. Priority inside SET_*: MODE, SELECT, INC,
  // auto-repeat, then timeout; lower-priority events in the same cycle are dropped.
  always_comb begin
    state_d     = state_q;
    pulse       = 1'b0;
    to_cnt_d    = to_cnt_q;
    blink_d     = blink_q;
    blink_cnt_d = blink_cnt_q;

    if (state_q == RUN) begin
      if (mode_evt) state_d = SET_HOUR;
    end else if (mode_evt) begin
      state_d = RUN;
    end else if (sel_evt) begin
      state_d = next_field(state_q);
    end else if (inc_evt || rep_pulse) begin
      pulse = 1'b1;
    end else if (to_cnt_q >= TIMEOUT_CYCLES) begin
      state_d = RUN;
    end

    // Idle counter only runs inside SET_* and saturates at TIMEOUT_CYCLES.
    if (mode_evt || sel_evt || inc_evt || rep_pulse || state_d != state_q || state_q == RUN)
      to_cnt_d = '0;
    else if (to_cnt_q < TIMEOUT_CYCLES)
      to_cnt_d = to_cnt_q + 32'd1;

    if (state_d == RUN) begin
      blink_d     = 1'b0;
      blink_cnt_d = '0;
    end else if (state_d != state_q) begin
      blink_d     = 1'b1;
      blink_cnt_d = '0;
    end else if (blink_cnt_q == BLINK_CYCLES - 27'd1) begin
      blink_d     = ~blink_q;
      blink_cnt_d = '0;
    end else begin
      blink_cnt_d = blink_cnt_q + 27'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      to_cnt_q    <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      mode_q      <= 1'b0;
      sel_q       <= FIELD_NONE;
      hour_q      <= 1'b0;
      min_q       <= 1'b0;
      sec_q       <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      to_cnt_q    <= to_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      mode_q      <= (state_d != RUN);
      sel_q       <= field_of(state_d);
      hour_q      <= pulse && (state_q == SET_HOUR);
      min_q       <= pulse && (state_q == SET_MIN);
      sec_q       <= pulse && (state_q == SET_SEC);
      valid_q     <= pulse;
    end
  end

  assign bus.mode           = mode_q;
  assign bus.sel_field      = sel_q;
  assign bus.change_hour    = hour_q;
  assign bus.change_minute  = min_q;
  assign bus.change_second  = sec_q;
  assign bus.valid_response = valid_q;
  assign bus.blink          = blink_q;
  assign bus.dbg_state      = state_q;

endmodule

// File: tb/tb_watch_set_controller.sv
// Bench for watch_set_controller with short timing parameters. A per-cycle
// reference model (debounce by run length, field index FSM, elapsed-cycle
// timers) predicts every output; directed steps cover the listed scenarios and
// a randomized tail exercises button mixes, timeouts and a mid-run reset.
`timescale 1ns/1ps
module tb_watch_set_controller;

  localparam int D    = 4;
  localparam int HOLD = 20;
  localparam int REP  = 5;
  localparam int TO   = 100;
  localparam int BL   = 8;

  localparam logic [2:0] B_MODE = 3'b001;
  localparam logic [2:0] B_SEL  = 3'b010;
  localparam logic [2:0] B_INC  = 3'b100;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  watch_set_controller_if bus();

  watch_set_controller #(
    .DEBOUNCE_CYCLES(20'd4),
    .HOLD_CYCLES(27'd20),
    .REPEAT_CYCLES(27'd5),
    .TIMEOUT_CYCLES(32'd100),
    .BLINK_CYCLES(27'd8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  logic [1:0] exp_q[$];
  int pulse_cyc[$];
  int cnt_h, cnt_m, cnt_s, cnt_v;

  // ---------------- reference model ----------------
  int m_f;           // -1 = RUN, otherwise selected field 0/1/2
  bit m_db  [3];     // debounced level per button
  bit m_evt [3];     // press event visible this cycle
  bit m_d1  [3];     // raw one edge ago
  bit m_d2  [3];     // raw two edges ago
  bit m_last[3];     // value of the current run of identical samples
  int m_run [3];     // length of that run
  int m_idle, m_bage, m_hage;
  bit m_armed;
  int e_pulse;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_f = -1; m_idle = 0; m_bage = 0; m_hage = 0; m_armed = 0; e_pulse = -1;
    for (int b = 0; b < 3; b++) begin
      m_db[b] = 0; m_evt[b] = 0; m_d1[b] = 0; m_d2[b] = 0; m_last[b] = 0; m_run[b] = 0;
    end
  endtask

  task automatic model_step(input logic [2:0] r);
    int old_f;
    bit rep;
    bit any;
    rep = 0; e_pulse = -1; old_f = m_f;
`ifdef WATCH_SET_AUTOREPEAT_EN
    if ((m_f == 0 || m_f == 1) && !m_evt[0] && !m_evt[1]) begin
      if (m_evt[2]) begin
        m_armed = 1; m_hage = 0;
      end else if (m_armed && m_db[2]) begin
        m_hage++;
        rep = (m_hage >= HOLD) && (((m_hage - HOLD) % REP) == 0);
      end else begin
        m_armed = 0;
      end
    end else begin
      m_armed = 0;
    end
`endif
    if (m_f < 0) begin
      if (m_evt[0]) m_f = 0;
    end else if (m_evt[0]) m_f = -1;
    else if (m_evt[1]) m_f = (m_f + 1) % 3;
    else if (m_evt[2] || rep) e_pulse = m_f;
    else if (m_idle >= TO) m_f = -1;

    any = m_evt[0] | m_evt[1] | m_evt[2] | rep;
    if (any || m_f != old_f || m_f < 0) m_idle = 0;
    else if (m_idle < TO) m_idle++;
    if (m_f < 0 || m_f != old_f) m_bage = 0;
    else m_bage++;
    if (e_pulse >= 0) exp_q.push_back(2'(e_pulse));

    // the debouncer at this edge sees the raw value from two edges earlier
    for (int b = 0; b < 3; b++) begin
      bit s;
      s = m_d2[b]; m_d2[b] = m_d1[b]; m_d1[b] = r[b];
      if (m_run[b] > 0 && s == m_last[b]) m_run[b]++;
      else m_run[b] = 1;
      m_last[b] = s;
      m_evt[b] = 0;
      if (m_run[b] >= D && s != m_db[b]) begin
        m_db[b] = s;
        m_evt[b] = s;
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic tick(input logic [2:0] r);
    logic [7:0] obs, exp;
    logic [1:0] obs_f;
    bus.btn_mode_raw = r[0];
    bus.btn_sel_raw  = r[1];
    bus.btn_inc_raw  = r[2];
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      model_step(r);
      exp = {(m_f >= 0), (m_f < 0) ? 2'd3 : 2'(m_f), (e_pulse == 0), (e_pulse == 1),
             (e_pulse == 2), (e_pulse >= 0), (m_f >= 0) && (((m_bage / BL) % 2) == 0)};
    end else begin
      exp = 8'b0_11_0000_0;
    end
    obs = {bus.mode, bus.sel_field, bus.change_hour, bus.change_minute,
           bus.change_second, bus.valid_response, bus.blink};
    check("outputs", {24'd0, obs}, {24'd0, exp});
    if (bus.valid_response) begin
      obs_f = bus.change_hour ? 2'd0 : bus.change_minute ? 2'd1 : bus.change_second ? 2'd2 : 2'd3;
      if (exp_q.size() == 0) check("spurious_pulse", {31'd0, bus.valid_response}, 32'd0);
      else check("pulse_field", {30'd0, obs_f}, {30'd0, exp_q.pop_front()});
      pulse_cyc.push_back(cyc);
      cnt_v++;
    end
    if (bus.change_hour)   cnt_h++;
    if (bus.change_minute) cnt_m++;
    if (bus.change_second) cnt_s++;
  endtask

  task automatic press(input logic [2:0] mask, input int len, input int gap);
    repeat (len) tick(mask);
    repeat (gap) tick(3'b000);
  endtask

  task automatic clear_stats();
    cnt_h = 0; cnt_m = 0; cnt_s = 0; cnt_v = 0;
    pulse_cyc.delete();
  endtask

  task automatic do_reset(input logic [2:0] held, input int cycles);
    rst = 1'b0;
    repeat (cycles) tick(held);
    model_reset();
    exp_q.delete();
    rst = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k;
    int n;
    logic [2:0] mask;
    bus.btn_mode_raw = 1'b0;
    bus.btn_sel_raw  = 1'b0;
    bus.btn_inc_raw  = 1'b0;
    model_reset();
    clear_stats();
    #1;
    do_reset(3'b000, 3);

    // 1: reset in SET_MIN with INC held
    press(B_MODE, 6, 10);
    press(B_SEL, 6, 10);
    check("t1_in_set_min", {30'd0, bus.sel_field}, 32'd1);
    repeat (3) tick(B_INC);
    clear_stats();
    do_reset(B_INC, 3);
    repeat (12) tick(B_INC);
    repeat (12) tick(3'b000);
    check("t1_no_pulse", cnt_v, 32'd0);
    check("t1_mode", {31'd0, bus.mode}, 32'd0);
    check("t1_sel", {30'd0, bus.sel_field}, 32'd3);

    // 2: two clean INC presses in SET_HOUR
    clear_stats();
    press(B_MODE, 6, 10);
    press(B_INC, 6, 10);
    press(B_INC, 6, 10);
    check("t2_hour_pulses", cnt_h, 32'd2);
    check("t2_min_pulses", cnt_m, 32'd0);
    check("t2_sec_pulses", cnt_s, 32'd0);
    check("t2_valid_pulses", cnt_v, 32'd2);
    check("t2_mode", {31'd0, bus.mode}, 32'd1);
    check("t2_sel", {30'd0, bus.sel_field}, 32'd0);

    // 3: glitch then real press
    clear_stats();
    press(B_INC, 3, 10);
    check("t3_glitch", cnt_v, 32'd0);
    press(B_INC, 6, 10);
    check("t3_press", cnt_h, 32'd1);

    // 4: MODE and SELECT together in SET_MIN
    clear_stats();
    press(B_SEL, 6, 10);
    check("t4_in_set_min", {30'd0, bus.sel_field}, 32'd1);
    press(B_MODE | B_SEL, 6, 10);
    check("t4_mode", {31'd0, bus.mode}, 32'd0);
    check("t4_sel", {30'd0, bus.sel_field}, 32'd3);
    check("t4_no_pulse", cnt_v, 32'd0);

    // 5: timeout from SET_SEC
    press(B_MODE, 6, 10);
    press(B_SEL, 6, 10);
    clear_stats();
    repeat (6) tick(B_SEL);
    k = 0;
    while (bus.sel_field != 2'd2 && k < 20) begin
      k++;
      tick(3'b000);
    end
    check("t5_entered_sec", {30'd0, bus.sel_field}, 32'd2);
    n = 0;
    while (bus.sel_field == 2'd2 && n < 300) begin
      n++;
      tick(3'b000);
    end
    check("t5_timeout_cycles", n, 32'd101);
    check("t5_mode", {31'd0, bus.mode}, 32'd0);
    check("t5_blink", {31'd0, bus.blink}, 32'd0);
    check("t5_no_second", cnt_s, 32'd0);

    // 6: INC held in SET_MIN
    press(B_MODE, 6, 10);
    press(B_SEL, 6, 10);
    clear_stats();
    press(B_INC, 45, 12);
`ifdef WATCH_SET_AUTOREPEAT_EN
    check("t6_repeat_count", cnt_m, 32'd6);
    for (int i = 1; i < pulse_cyc.size(); i++)
      check("t6_gap", pulse_cyc[i] - pulse_cyc[i-1], (i == 1) ? HOLD : REP);
`else
    check("t6_single_pulse", cnt_m, 32'd1);
`endif
    check("t6_other_fields", cnt_h + cnt_s, 32'd0);
    press(B_MODE, 6, 10);

    // randomized tail
    for (int it = 0; it < 160; it++) begin
      k = $urandom_range(0, 9);
      if (k < 3)      mask = B_MODE;
      else if (k < 5) mask = B_SEL;
      else if (k < 8) mask = B_INC;
      else            mask = 3'($urandom_range(1, 7));
      if ($urandom_range(0, 11) == 0) press(B_INC, $urandom_range(25, 45), 10);
      else press(mask, $urandom_range(1, 9), $urandom_range(0, 14));
      if ($urandom_range(0, 12) == 0) repeat (110) tick(3'b000);
      if (it == 80) do_reset(3'($urandom_range(0, 7)), 2);
    end
    repeat (20) tick(3'b000);
    check("pending_pulses", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
